// File: rtl/medidor_escalonador.sv
// Round-robin scheduler for four sensors sharing one measurement unit and one serial transmitter.
// Each measurement has a watchdog, and sticky per-channel timeout flags are kept.
module medidor_escalonador #(
  parameter int TIMEOUT   = 1000,
  parameter int INTERVALO = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] habilita,
  input  logic       fim_medida,
  input  logic       fim_envio,
  output logic [1:0] sel_sensor,
  output logic       mede,
  output logic       envia,
  output logic [3:0] erro,
  output logic       ocupado,
  output logic       pronto,
  output logic [7:0] rodadas,
  output logic [2:0] db_estado
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(INTERVALO + 1);

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    SELECIONA      = 3'd1,
    DISPARA        = 3'd2,
    AGUARDA_MEDIDA = 3'd3,
    TRANSMITE      = 3'd4,
    AGUARDA_ENVIO  = 3'd5,
    PROXIMO        = 3'd6,
    INTERVALO_ST   = 3'd7
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [1:0]      index_q, index_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      mascara_q, mascara_d;
  logic [3:0]      erro_q, erro_d;
  logic [7:0]      rodadas_q, rodadas_d;
  logic            stop_q, stop_d;
  logic            pronto_q, pronto_d;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic [IW-1:0]   intv_q, intv_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      index_q   <= '0;
      sel_q     <= '0;
      mascara_q <= '0;
      erro_q    <= '0;
      rodadas_q <= '0;
      stop_q    <= 1'b0;
      pronto_q  <= 1'b0;
      wdog_q    <= '0;
      intv_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      index_q   <= index_d;
      sel_q     <= sel_d;
      mascara_q <= mascara_d;
      erro_q    <= erro_d;
      rodadas_q <= rodadas_d;
      stop_q    <= stop_d;
      pronto_q  <= pronto_d;
      wdog_q    <= wdog_d;
      intv_q    <= intv_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    index_d   = index_q;
    sel_d     = sel_q;
    mascara_d = mascara_q;
    erro_d    = erro_q;
    rodadas_d = rodadas_q;
    pronto_d  = 1'b0;
    wdog_d    = wdog_q;
    intv_d    = intv_q;
    // A stop request seen this very cycle already counts for end-of-round decisions.
    stop_d    = stop_q | (parar & (estado_q != OCIOSO));

    case (estado_q)
      OCIOSO: begin
        if (iniciar && (habilita != 4'b0000)) begin
          estado_d  = SELECIONA;
          mascara_d = habilita;
          index_d   = 2'd0;
          erro_d    = 4'b0000;
          rodadas_d = 8'd0;
          stop_d    = 1'b0;
        end
      end
      SELECIONA: begin
        if (mascara_q[index_q]) begin
          estado_d = DISPARA;
          sel_d    = index_q;
        end else begin
          estado_d = PROXIMO;
        end
      end
      DISPARA: begin
        wdog_d   = '0;
        estado_d = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA: begin
        if (fim_medida) begin
          estado_d = TRANSMITE;
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          erro_d[index_q] = 1'b1;
          estado_d        = PROXIMO;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      TRANSMITE: begin
        estado_d = AGUARDA_ENVIO;
      end
      AGUARDA_ENVIO: begin
        if (fim_envio) begin
          estado_d = PROXIMO;
        end
      end
      PROXIMO: begin
        if (index_q != 2'd3) begin
          index_d  = index_q + 2'd1;
          estado_d = SELECIONA;
        end else begin
          rodadas_d = rodadas_q + 8'd1;
          if (stop_d) begin
            estado_d = OCIOSO;
            pronto_d = 1'b1;
            stop_d   = 1'b0;
          end else begin
            estado_d = INTERVALO_ST;
            intv_d   = '0;
          end
        end
      end
      INTERVALO_ST: begin
        if (stop_d) begin
          estado_d = OCIOSO;
          pronto_d = 1'b1;
          stop_d   = 1'b0;
        end else if (intv_q == IW'(INTERVALO - 1)) begin
          estado_d  = SELECIONA;
          index_d   = 2'd0;
          mascara_d = habilita;
        end else begin
          intv_d = intv_q + IW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign sel_sensor = sel_q;
  assign mede       = (estado_q == DISPARA);
  assign envia      = (estado_q == TRANSMITE);
  assign erro       = erro_q;
  assign ocupado    = (estado_q != OCIOSO);
  assign pronto     = pronto_q;
  assign rodadas    = rodadas_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_medidor_escalonador.sv
// Scoreboard bench for medidor_escalonador: directed scenarios push expected pulses,
// a monitor pops them whenever mede, envia or pronto is seen.
module tb_medidor_escalonador;
  localparam int TO = 8;
  localparam int IV = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, parar, fim_medida, fim_envio;
  logic [3:0] habilita;
  logic [1:0] sel_sensor;
  logic       mede, envia, ocupado, pronto;
  logic [3:0] erro;
  logic [7:0] rodadas;
  logic [2:0] db_estado;

  medidor_escalonador #(.TIMEOUT(TO), .INTERVALO(IV)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .habilita(habilita), .fim_medida(fim_medida), .fim_envio(fim_envio),
    .sel_sensor(sel_sensor), .mede(mede), .envia(envia), .erro(erro),
    .ocupado(ocupado), .pronto(pronto), .rodadas(rodadas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int med_dly[4];
  int env_dly = 5;
  int med_cnt = 0;
  int env_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, expv);
    end
  endtask

  task automatic push_m(input logic [1:0] s);
    exp_q.push_back({4'd1, 2'b00, s, 8'd0});
  endtask
  task automatic push_e(input logic [1:0] s);
    exp_q.push_back({4'd2, 2'b00, s, 8'd0});
  endtask
  task automatic push_p(input logic [3:0] er, input logic [7:0] rod);
    exp_q.push_back({4'd3, er, rod});
  endtask
  task automatic push_round();
    for (int s = 0; s < 4; s++) begin
      push_m(2'(s));
      push_e(2'(s));
    end
  endtask

  task automatic pop_cmp(input string nm, input logic [15:0] got);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got=%0h want=none", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL event_%s got=%0h want=%0h", nm, got, e);
      end
    end
  endtask

  // Monitor: compares every output pulse against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clock);
      if (mede === 1'b1)   pop_cmp("mede",   {4'd1, 2'b00, sel_sensor, 8'd0});
      if (envia === 1'b1)  pop_cmp("envia",  {4'd2, 2'b00, sel_sensor, 8'd0});
      if (pronto === 1'b1) pop_cmp("pronto", {4'd3, erro, rodadas});
    end
  end

  // Responder: models the measurement unit and transmitter latencies.
  initial begin
    fim_medida = 1'b0;
    fim_envio  = 1'b0;
    forever begin
      @(negedge clock);
      fim_medida = 1'b0;
      fim_envio  = 1'b0;
      if (reset !== 1'b1) begin
        med_cnt = 0;
        env_cnt = 0;
      end else begin
        if (med_cnt > 0) begin
          med_cnt--;
          if (med_cnt == 0) fim_medida = 1'b1;
        end
        if (env_cnt > 0) begin
          env_cnt--;
          if (env_cnt == 0) fim_envio = 1'b1;
        end
        if (mede === 1'b1)  med_cnt = med_dly[sel_sensor];
        if (envia === 1'b1) env_cnt = env_dly;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start(input logic [3:0] hab);
    habilita = hab;
    iniciar  = 1'b1;
    @(negedge clock);
    iniciar  = 1'b0;
  endtask

  task automatic pulse_parar();
    parar = 1'b1;
    @(negedge clock);
    parar = 1'b0;
  endtask

  task automatic wait_st(input logic [2:0] code, input int sel, input int bound, input string nm);
    int n = 0;
    while (!(db_estado == code && (sel < 0 || int'(sel_sensor) == sel)) && n < bound) begin
      @(negedge clock);
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL wait_%s got=timeout want=state%0d", nm, code);
    end
  endtask

  task automatic wait_idle(output bit saw_int, input string nm);
    int n = 0;
    saw_int = 1'b0;
    while (db_estado != 3'd0 && n < 2000) begin
      @(negedge clock);
      if (db_estado == 3'd7) saw_int = 1'b1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_%s got=timeout want=OCIOSO", nm);
    end
  endtask

  task automatic count_in(input logic [2:0] code, output int n);
    n = 0;
    while (db_estado == code && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"},     32'(sel_sensor), 32'd0);
    chk({tag, "_mede"},    32'(mede),       32'd0);
    chk({tag, "_envia"},   32'(envia),      32'd0);
    chk({tag, "_pronto"},  32'(pronto),     32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado),    32'd0);
    chk({tag, "_erro"},    32'(erro),       32'd0);
    chk({tag, "_rodadas"}, 32'(rodadas),    32'd0);
    chk({tag, "_estado"},  32'(db_estado),  32'd0);
  endtask

  initial begin
    bit saw;
    int n;
    reset    = 1'b0;
    iniciar  = 1'b0;
    parar    = 1'b0;
    habilita = 4'b0000;
    for (int i = 0; i < 4; i++) med_dly[i] = 3;
    tick(3);
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick(2);

    // Full round, interval length, then a second round stopped by parar.
    push_round();
    start(4'b1111);
    chk("lat_estado", 32'(db_estado), 32'd1);
    chk("lat_ocupado", 32'(ocupado), 32'd1);
    tick(1);
    chk("lat_mede", 32'(mede), 32'd1);
    wait_st(3'd7, -1, 400, "intervalo");
    chk("r1_rodadas", 32'(rodadas), 32'd1);
    push_round();
    push_p(4'b0000, 8'd2);
    count_in(3'd7, n);
    chk("intervalo_len", 32'(n), 32'(IV));
    chk("intervalo_next", 32'(db_estado), 32'd1);
    pulse_parar();
    wait_idle(saw, "r2");
    chk("r2_rodadas", 32'(rodadas), 32'd2);

    // Sparse mask 0101.
    push_m(2'd0); push_e(2'd0); push_m(2'd2); push_e(2'd2);
    push_p(4'b0000, 8'd1);
    start(4'b0101);
    pulse_parar();
    wait_idle(saw, "mask");
    chk("mask_erro", 32'(erro), 32'd0);

    // Sensor 1 never answers: timeout after 8 cycles.
    med_dly[1] = 0;
    push_m(2'd0); push_e(2'd0); push_m(2'd1);
    push_m(2'd2); push_e(2'd2); push_m(2'd3); push_e(2'd3);
    push_p(4'b0010, 8'd1);
    start(4'b1111);
    pulse_parar();
    wait_st(3'd3, 1, 200, "s1_wait");
    count_in(3'd3, n);
    chk("to_len", 32'(n), 32'(TO));
    chk("to_erro", 32'(erro), 32'b0010);
    chk("to_next", 32'(db_estado), 32'd6);
    wait_idle(saw, "to");
    chk("to_erro_end", 32'(erro), 32'b0010);
    med_dly[1] = 3;

    // parar during sensor 1 measurement.
    push_round();
    push_p(4'b0000, 8'd1);
    start(4'b1111);
    wait_st(3'd3, 1, 200, "stop_s1");
    pulse_parar();
    wait_idle(saw, "stop");
    chk("stop_no_intervalo", 32'(saw), 32'd0);
    chk("stop_rodadas", 32'(rodadas), 32'd1);

    // fim_medida on the timeout cycle of sensor 2.
    med_dly[2] = TO;
    push_round();
    push_p(4'b0000, 8'd1);
    start(4'b1111);
    pulse_parar();
    wait_st(3'd3, 2, 200, "race_s2");
    count_in(3'd3, n);
    chk("race_len", 32'(n), 32'(TO));
    chk("race_next", 32'(db_estado), 32'd4);
    wait_idle(saw, "race");
    chk("race_erro", 32'(erro), 32'd0);
    med_dly[2] = 3;

    // Asynchronous reset in AGUARDA_ENVIO.
    push_m(2'd0); push_e(2'd0);
    start(4'b1111);
    wait_st(3'd5, -1, 100, "envio");
    #2 reset = 1'b0;
    #1 chk_reset_outputs("arst");
    @(negedge clock);
    tick(1);
    reset = 1'b1;
    tick(5);
    chk("arst_idle", 32'(db_estado), 32'd0);
    habilita = 4'b0000;
    iniciar  = 1'b1;
    tick(1);
    iniciar  = 1'b0;
    tick(3);
    chk("hab0_estado", 32'(db_estado), 32'd0);
    chk("hab0_ocupado", 32'(ocupado), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
